// File: rtl/bus16_arbiter_pkg.sv
// Shared definitions for bus masters on the Buffer16-driven data bus.
// Provides the bus width, the arbiter state encoding and a modular increment helper.
package bus16_arbiter_pkg;

   localparam int BUS_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/bus16_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping past NUM_REQ-1 back to 0. Returns one-hot, index and an any-request flag.
module rr_pick
   import bus16_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
   output logic [NUM_REQ-1:0]         o_onehot,
   output logic [$clog2(NUM_REQ)-1:0] o_idx,
   output logic                       o_any
);

   localparam int          IW  = $clog2(NUM_REQ);
   localparam int unsigned N_U = NUM_REQ;

   always_comb begin
      int unsigned w_pos;
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      w_pos    = 0;
      for (int unsigned off = 0; off < N_U; off++) begin
         w_pos = int'(i_ptr) + off;
         if (w_pos >= N_U) begin
            w_pos = w_pos - N_U;
         end
         if (!o_any && i_req[w_pos]) begin
            o_any           = 1'b1;
            o_idx           = IW'(w_pos);
            o_onehot[w_pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus16_arbiter.sv
// Round-robin owner arbitration for the shared registered 16-bit bus, with a
// per-grant hold limit and a one-cycle turnaround gap between owners.
module bus16_arbiter
   import bus16_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int WIDTH    = BUS_WIDTH,
   parameter int MAX_HOLD = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         wvalid,
   input  logic [NUM_REQ*WIDTH-1:0]   wdata,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       bus_valid,
   output logic [WIDTH-1:0]           bus_data,
   output logic [$clog2(NUM_REQ)-1:0] bus_owner
);

   localparam int          IW  = $clog2(NUM_REQ);
   localparam int          HW  = $clog2(MAX_HOLD) + 1;
   localparam int unsigned N_U = NUM_REQ;

   arb_state_t         r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic [IW-1:0]      r_ptr;
   logic [IW-1:0]      r_owner;
   logic [HW-1:0]      r_hold;
   logic               r_valid;
   logic [WIDTH-1:0]   r_data;

   logic [NUM_REQ-1:0] w_pick_oh;
   logic [IW-1:0]      w_pick_idx;
   logic               w_pick_any;
   logic               w_owner_req;
   logic               w_owner_wvalid;
   logic [WIDTH-1:0]   w_owner_data;
   logic               w_release;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx),
      .o_any    (w_pick_any)
   );

   assign w_owner_req    = req[r_owner];
   assign w_owner_wvalid = wvalid[r_owner];
   assign w_owner_data   = wdata[int'(r_owner)*WIDTH +: WIDTH];
   assign w_release      = !w_owner_req || (r_hold == HW'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_ptr   <= '0;
         r_owner <= '0;
         r_hold  <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         // Only the current owner's word reaches the bus, including on its release cycle.
         r_valid <= 1'b0;
         if (r_state == ST_OWN && w_owner_wvalid) begin
            r_valid <= 1'b1;
            r_data  <= w_owner_data;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_pick_any) begin
                  r_gnt   <= w_pick_oh;
                  r_owner <= w_pick_idx;
                  r_hold  <= '0;
                  r_state <= ST_OWN;
               end
            end
            ST_OWN: begin
               if (w_release) begin
                  r_gnt   <= '0;
                  r_ptr   <= IW'(wrap_inc(int'(r_owner), N_U));
                  r_state <= ST_GAP;
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            ST_GAP: begin
               // Arbitrate here so a waiting request sees exactly one idle bus cycle.
               if (w_pick_any) begin
                  r_gnt   <= w_pick_oh;
                  r_owner <= w_pick_idx;
                  r_hold  <= '0;
                  r_state <= ST_OWN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_gnt   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign bus_valid = r_valid;
   assign bus_data  = r_data;
   assign bus_owner = r_owner;

endmodule

// File: tb/tb_bus16_arbiter.sv
// Self-checking bench for bus16_arbiter: cycle vectors from a table plus
// hand-built round-robin, early-release and async-reset sequences.
module tb_bus16_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int MH = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N-1:0]   wvalid = '0;
   logic [N*W-1:0] wdata = '0;
   logic [N-1:0]   gnt;
   logic           bus_valid;
   logic [W-1:0]   bus_data;
   logic [1:0]     bus_owner;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bus16_arbiter #(
      .NUM_REQ  (N),
      .WIDTH    (W),
      .MAX_HOLD (MH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .wvalid    (wvalid),
      .wdata     (wdata),
      .gnt       (gnt),
      .bus_valid (bus_valid),
      .bus_data  (bus_data),
      .bus_owner (bus_owner)
   );

   typedef struct {
      string       name;
      logic        rst_n;
      logic [3:0]  req;
      logic [3:0]  wv;
      logic [63:0] wd;
      logic [3:0]  eg;
      logic        ev;
      logic [15:0] ed;
   } vec_t;

   typedef struct {
      string       name;
      logic [3:0]  eg;
      logic        ev;
      logic [15:0] ed;
      logic        cd;
   } exp_t;

   vec_t vt[$];
   exp_t sb[$];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic vec_t mk(string name, logic r, logic [3:0] rq, logic [3:0] wv,
                               logic [63:0] wd, logic [3:0] eg, logic ev, logic [15:0] ed);
      vec_t v;
      v.name = name; v.rst_n = r; v.req = rq; v.wv = wv; v.wd = wd;
      v.eg = eg; v.ev = ev; v.ed = ed;
      return v;
   endfunction

   task automatic compare();
      exp_t       e;
      logic [1:0] eo;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      check({e.name, ".gnt"}, 32'(gnt), 32'(e.eg));
      check({e.name, ".valid"}, 32'(bus_valid), 32'(e.ev));
      if (e.cd) check({e.name, ".data"}, 32'(bus_data), 32'(e.ed));
      if (e.eg != 4'b0000) begin
         eo = '0;
         for (int i = 0; i < N; i++) if (e.eg[i]) eo = 2'(i);
         check({e.name, ".owner"}, 32'(bus_owner), 32'(eo));
      end
      check({e.name, ".onehot0"}, 32'($onehot0(gnt)), 32'd1);
   endtask

   // Drive one cycle of inputs, queue what the next edge must produce, then compare.
   task automatic drive(string name, logic r, logic [3:0] rq, logic [3:0] wv, logic [63:0] wd,
                        logic [3:0] eg, logic ev, logic [15:0] ed, logic cd);
      exp_t e;
      rst_n = r; req = rq; wvalid = wv; wdata = wd;
      e.name = name; e.eg = eg; e.ev = ev; e.ed = ed; e.cd = cd;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] oh;

      vt.push_back(mk("rst_hold0",    0, 4'b1111, 4'b0000, 64'h0,                   4'b0000, 0, 16'h0000));
      vt.push_back(mk("rst_hold1",    0, 4'b1111, 4'b0000, 64'h0,                   4'b0000, 0, 16'h0000));
      vt.push_back(mk("rst_release",  1, 4'b1111, 4'b0000, 64'h0,                   4'b0001, 0, 16'h0000));
      vt.push_back(mk("rel0",         1, 4'b0000, 4'b0000, 64'h0,                   4'b0000, 0, 16'h0000));
      vt.push_back(mk("gap0",         1, 4'b0000, 4'b0000, 64'h0,                   4'b0000, 0, 16'h0000));
      vt.push_back(mk("single_gnt",   1, 4'b0100, 4'b0100, 64'h0000_BEEF_0000_0000, 4'b0100, 0, 16'h0000));
      vt.push_back(mk("single_data",  1, 4'b0100, 4'b0100, 64'h0000_BEEF_0000_0000, 4'b0100, 1, 16'hBEEF));
      vt.push_back(mk("single_rel",   1, 4'b0000, 4'b0000, 64'h0,                   4'b0000, 0, 16'hBEEF));
      vt.push_back(mk("single_idle",  1, 4'b0000, 4'b0000, 64'h0,                   4'b0000, 0, 16'hBEEF));
      vt.push_back(mk("wrap_gnt0",    1, 4'b0101, 4'b0100, 64'h0000_1234_0000_0000, 4'b0001, 0, 16'hBEEF));
      vt.push_back(mk("nonowner_a",   1, 4'b0101, 4'b0100, 64'h0000_1234_0000_0000, 4'b0001, 0, 16'hBEEF));
      vt.push_back(mk("nonowner_b",   1, 4'b0101, 4'b0100, 64'h0000_1234_0000_0000, 4'b0001, 0, 16'hBEEF));
      vt.push_back(mk("owner_word",   1, 4'b0101, 4'b0101, 64'h0000_1234_0000_CAFE, 4'b0001, 1, 16'hCAFE));
      vt.push_back(mk("rel_capture",  1, 4'b0100, 4'b0001, 64'h0000_0000_0000_5A5A, 4'b0000, 1, 16'h5A5A));
      vt.push_back(mk("gap_regrant",  1, 4'b0100, 4'b0000, 64'h0,                   4'b0100, 0, 16'h5A5A));
      vt.push_back(mk("rel2",         1, 4'b0000, 4'b0000, 64'h0,                   4'b0000, 0, 16'h5A5A));
      vt.push_back(mk("idle_end",     1, 4'b0000, 4'b0000, 64'h0,                   4'b0000, 0, 16'h5A5A));

      foreach (vt[i])
         drive(vt[i].name, vt[i].rst_n, vt[i].req, vt[i].wv, vt[i].wd,
               vt[i].eg, vt[i].ev, vt[i].ed, 1'b1);

      // Round robin with all requests held: 8-cycle tenures, one gap cycle each.
      drive("rr_rst", 0, 4'b1111, 4'b0000, 64'h0, 4'b0000, 0, 16'h0000, 1'b1);
      for (int r = 0; r < 5; r++) begin
         oh = 4'b0001 << (r % 4);
         for (int c = 0; c < MH; c++)
            drive($sformatf("rr_own%0d_c%0d", r, c), 1, 4'b1111, 4'b0000, 64'h0, oh, 0, 16'h0, 1'b0);
         if (r < 4)
            drive($sformatf("rr_gap%0d", r), 1, 4'b1111, 4'b0000, 64'h0, 4'b0000, 0, 16'h0, 1'b0);
      end

      // Early release by owner 1 while requester 3 waits.
      drive("early_rst", 0, 4'b1010, 4'b0000, 64'h0, 4'b0000, 0, 16'h0000, 1'b1);
      for (int c = 0; c < 3; c++)
         drive($sformatf("early_own1_c%0d", c), 1, 4'b1010, 4'b0000, 64'h0, 4'b0010, 0, 16'h0, 1'b1);
      drive("early_gap",  1, 4'b1000, 4'b0000, 64'h0, 4'b0000, 0, 16'h0, 1'b1);
      drive("early_own3", 1, 4'b1000, 4'b0000, 64'h0, 4'b1000, 0, 16'h0, 1'b1);
      drive("early_own3b",1, 4'b1000, 4'b0000, 64'h0, 4'b1000, 0, 16'h0, 1'b1);

      // Async reset in the 4th cycle of owner 2's tenure, pointer having moved to 2.
      drive("ar_rst",   0, 4'b0000, 4'b0000, 64'h0, 4'b0000, 0, 16'h0000, 1'b1);
      drive("ar_own1",  1, 4'b0010, 4'b0000, 64'h0, 4'b0010, 0, 16'h0000, 1'b1);
      drive("ar_rel1",  1, 4'b0100, 4'b0100, 64'h0000_7777_0000_0000, 4'b0000, 0, 16'h0000, 1'b1);
      drive("ar_own2a", 1, 4'b0100, 4'b0100, 64'h0000_7777_0000_0000, 4'b0100, 0, 16'h0000, 1'b1);
      drive("ar_own2b", 1, 4'b0100, 4'b0100, 64'h0000_7777_0000_0000, 4'b0100, 1, 16'h7777, 1'b1);
      drive("ar_own2c", 1, 4'b0100, 4'b0100, 64'h0000_7777_0000_0000, 4'b0100, 1, 16'h7777, 1'b1);
      drive("ar_own2d", 1, 4'b0100, 4'b0100, 64'h0000_7777_0000_0000, 4'b0100, 1, 16'h7777, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_async.gnt",   32'(gnt),       32'd0);
      check("ar_async.valid", 32'(bus_valid), 32'd0);
      check("ar_async.data",  32'(bus_data),  32'd0);
      check("ar_async.owner", 32'(bus_owner), 32'd0);
      @(negedge clk);
      drive("ar_hold",    0, 4'b1111, 4'b0000, 64'h0, 4'b0000, 0, 16'h0000, 1'b1);
      drive("ar_restart", 1, 4'b1111, 4'b0000, 64'h0, 4'b0001, 0, 16'h0000, 1'b1);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
